// File: rtl/hog_pkg.sv
// Shared types and fixed-point widths for the HOG cell/block normalisation path.
package hog_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  localparam int HOG_O_I_W = 4;
  localparam int HOG_O_F_W = 8;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift one dividend bit into the remainder and
// subtract the divisor when it fits.
module div_step #(
  parameter int B_W = 9
) (
  input  logic [B_W:0]   rem_i,
  input  logic           bit_i,
  input  logic [B_W-1:0] b_i,
  output logic [B_W:0]   rem_o,
  output logic           q_o
);

  logic [B_W:0] sh;

  // The bit shifted out of rem_i only matters as "definitely >= b"; the
  // wrapped subtraction is exact because the true difference is below b.
  assign sh    = {rem_i[B_W-1:0], bit_i};
  assign q_o   = rem_i[B_W] | (sh >= {1'b0, b_i});
  assign rem_o = q_o ? (sh - {1'b0, b_i}) : sh;

endmodule

// File: rtl/div_seq.sv
// Iterative unsigned fixed-point divider, o = (a << O_F_W) / b, with
// saturation on divide-by-zero and integer overflow.
module div_seq
  import hog_pkg::*;
#(
  parameter int A_W          = 9,
  parameter int B_W          = 9,
  parameter int O_I_W        = HOG_O_I_W,
  parameter int O_F_W        = HOG_O_F_W,
  parameter int BITS_PER_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_W-1:0]         a,
  input  logic [B_W-1:0]         b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [O_I_W+O_F_W-1:0] o,
  output logic                   dz,
  output logic                   ovf
);

  localparam int O_W   = O_I_W + O_F_W;
  localparam int N     = A_W + O_F_W;
  localparam int N_P   = BITS_PER_CYC * ((N + BITS_PER_CYC - 1) / BITS_PER_CYC);
  localparam int ITER  = N_P / BITS_PER_CYC;
  localparam int CNT_W = $clog2(ITER + 1);

  if (!(BITS_PER_CYC == 1 || BITS_PER_CYC == 2 || BITS_PER_CYC == 4)) begin : g_bad_bpc
    $error("div_seq: BITS_PER_CYC must be 1, 2 or 4");
  end

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [N_P-1:0]     div_q, div_d;
  logic [B_W:0]       rem_q, rem_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [O_W-1:0]     o_q, o_d;
  logic               dz_q, dz_d, ovf_q, ovf_d;

  logic [BITS_PER_CYC:0][B_W:0] rem_c;
  logic [BITS_PER_CYC-1:0]      qbits;
  logic [N_P-1:0]               div_nxt;
  logic                         sat;

  assign rem_c[0] = rem_q;

  for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_step
    div_step #(.B_W(B_W)) u_step (
      .rem_i (rem_c[k]),
      .bit_i (div_q[N_P-1-k]),
      .b_i   (b_q),
      .rem_o (rem_c[k+1]),
      .q_o   (qbits[BITS_PER_CYC-1-k])
    );
  end

  assign div_nxt = {div_q[N_P-BITS_PER_CYC-1:0], qbits};
  assign sat     = |(div_nxt >> O_W);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_d     = div_q;
    rem_d     = rem_q;
    b_d       = b_q;
    o_d       = o_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          div_d = N_P'({a, {O_F_W{1'b0}}});
          rem_d = '0;
          b_d   = b;
          ovf_d = 1'b0;
          if (b == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            o_d     = '1;
          end else begin
            state_d = BUSY;
            dz_d    = 1'b0;
            count_d = CNT_W'(ITER);
          end
        end
      end
      BUSY: begin
        div_d   = div_nxt;
        rem_d   = rem_c[BITS_PER_CYC];
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
          ovf_d   = sat;
          o_d     = sat ? '1 : div_nxt[O_W-1:0];
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      o_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      o_q     <= o_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o   = o_q;
  assign dz  = dz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed vectors on BITS_PER_CYC = 1/2/4 instances plus a
// scoreboard model checking the BITS_PER_CYC=1 instance every valid cycle.
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] a_in = '0, b_in = '0;
  logic       iv [3];
  logic       ordy [3];
  logic       ir [3];
  logic       ov [3];
  logic [11:0] oo [3];
  logic       odz [3];
  logic       oovf [3];

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q [$];

  always #5 clk = ~clk;

  div_seq #(.BITS_PER_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_in), .b(b_in),
    .out_valid(ov[0]), .out_ready(ordy[0]), .o(oo[0]), .dz(odz[0]), .ovf(oovf[0]));
  div_seq #(.BITS_PER_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_in), .b(b_in),
    .out_valid(ov[1]), .out_ready(ordy[1]), .o(oo[1]), .dz(odz[1]), .ovf(oovf[1]));
  div_seq #(.BITS_PER_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_in), .b(b_in),
    .out_valid(ov[2]), .out_ready(ordy[2]), .o(oo[2]), .dz(odz[2]), .ovf(oovf[2]));

  // Reference: {dz, ovf, o} straight from the arithmetic definition.
  function automatic logic [13:0] model(input logic [8:0] a, input logic [8:0] b);
    int unsigned q;
    if (b == 0) return {2'b10, 12'hFFF};
    q = (int'(a) * 256) / int'(b);
    if (q >= 4096) return {2'b01, 12'hFFF};
    return {2'b00, q[11:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard compare for the BITS_PER_CYC=1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", 32'(ov[0]), 32'd0);
      chk("rst_in_ready", 32'(ir[0]), 32'd1);
    end else begin
      if (ov[0]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(ov[0]), 32'd0);
        end else begin
          chk("model_result", {18'd0, odz[0], oovf[0], oo[0]}, {18'd0, exp_q[0]});
          chk("in_ready_when_valid", 32'(ir[0]), 32'd0);
          if (ordy[0]) void'(exp_q.pop_front());
        end
      end
      if (iv[0] && ir[0]) exp_q.push_back(model(a_in, b_in));
    end
  end

  // Drive one op on instance u, return latency and the result seen.
  task automatic run_op(input int u, input logic [8:0] a, input logic [8:0] b,
                        output int lat, output logic [13:0] res);
    logic acc_now;
    int guard;
    a_in = a; b_in = b; iv[u] = 1'b1;
    guard = 0;
    do begin
      acc_now = ir[u];
      @(posedge clk); #1;
      guard++;
    end while (!acc_now && guard < 200);
    iv[u] = 1'b0;
    if (!acc_now) chk("accept_timeout", 32'd0, 32'd1);
    lat = 1;
    while (!ov[u] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov[u]) chk("result_timeout", 32'd0, 32'd1);
    res = {odz[u], oovf[u], oo[u]};
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
  endtask

  int lat;
  logic [13:0] res, cap;

  initial begin
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(ir[0]), 32'd1);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_o", 32'(oo[0]), 32'd0);
    chk("reset_dz", 32'(odz[0]), 32'd0);
    chk("reset_ovf", 32'(oovf[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 100/10 = 10.0 in 4.8 -> 0xA00
    run_op(0, 9'd100, 9'd10, lat, res);
    chk("t1_lat", lat, 18);
    chk("t1_res", 32'(res), 32'h0A00);

    // 1/3 truncates to 0x055 whatever the radix
    run_op(0, 9'd1, 9'd3, lat, res);
    chk("t2_lat_bpc1", lat, 18); chk("t2_res_bpc1", 32'(res), 32'h0055);
    run_op(1, 9'd1, 9'd3, lat, res);
    chk("t2_lat_bpc2", lat, 10); chk("t2_res_bpc2", 32'(res), 32'h0055);
    run_op(2, 9'd1, 9'd3, lat, res);
    chk("t2_lat_bpc4", lat, 6);  chk("t2_res_bpc4", 32'(res), 32'h0055);

    run_op(0, 9'd5, 9'd0, lat, res);
    chk("t3_lat", lat, 1); chk("t3_dz", 32'(res), 32'h2FFF);
    run_op(0, 9'd300, 9'd2, lat, res);
    chk("t4_ovf", 32'(res), 32'h1FFF);
    run_op(0, 9'd511, 9'd511, lat, res);
    chk("max_max", 32'(res), 32'h0100);
    run_op(0, 9'd0, 9'd7, lat, res);
    chk("a_zero", 32'(res), 32'h0000);
    run_op(0, 9'd15, 9'd1, lat, res);
    chk("b1_a15", 32'(res), 32'h0F00);
    run_op(0, 9'd16, 9'd1, lat, res);
    chk("b1_a16", 32'(res), 32'h1FFF);
    run_op(2, 9'd200, 9'd100, lat, res);
    chk("bpc4_200_100", 32'(res), 32'h0200);
    run_op(1, 9'd511, 9'd1, lat, res);
    chk("bpc2_ovf", 32'(res), 32'h1FFF);
    run_op(2, 9'd0, 9'd0, lat, res);
    chk("bpc4_dz", 32'(res), 32'h2FFF);

    // Backpressure: result must hold for 20 cycles with out_ready low
    a_in = 9'd77; b_in = 9'd9; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 200) begin @(posedge clk); #1; lat++; end
    cap = {odz[0], oovf[0], oo[0]};
    chk("bp_value", 32'(cap), 32'h088E);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(ov[0]), 32'd1);
      chk("bp_hold_res", 32'({odz[0], oovf[0], oo[0]}), 32'(cap));
      chk("bp_in_ready", 32'(ir[0]), 32'd0);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("bp_release_in_ready", 32'(ir[0]), 32'd1);
    run_op(0, 9'd50, 9'd5, lat, res);
    chk("bp_next_lat", lat, 18); chk("bp_next_res", 32'(res), 32'h0A00);

    // Asynchronous reset in the middle of BUSY
    a_in = 9'd123; b_in = 9'd4; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 9'd50, 9'd5, lat, res);
    chk("postrst_res", 32'(res), 32'h0A00);

    // Random traffic with gaps; results checked by the scoreboard
    for (int n = 0; n < 300; n++) begin
      logic [8:0] ra, rb;
      int gap;
      ra = 9'($urandom_range(0, 511));
      rb = ($urandom_range(0, 15) == 0) ? 9'd0 :
           ($urandom_range(0, 3) == 0) ? 9'($urandom_range(1, 40)) : 9'($urandom_range(1, 511));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a_in = ra; b_in = rb; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      gap = 0;
      while (!ov[0] && gap < 200) begin @(posedge clk); #1; gap++; end
      if (!ov[0]) chk("rand_timeout", 32'd0, 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
    end
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
